// File: rtl/riscv_retire_tracker.sv
// Retirement tracker: counts retired instructions and cycles, mirrors the last
// architectural result, and detects the two-instruction halt sequence.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_RUN    | normal retirement, waiting for the arming instruction
// S_ARMED  | arming instruction retired, the next retirement decides halt
// S_HALTED | program finished; counters and result frozen until RST
module riscv_retire_tracker #(
    parameter logic [31:0] P_NUM_INST_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WB_VALID,
    input  logic [31:0] WB_INST,
    input  logic        WB_RF_WE,
    input  logic [31:0] WB_WD,
    input  logic        WB_IS_STORE,
    input  logic [31:0] WB_ADDR,
    input  logic        WB_IS_BRANCH,
    input  logic        WB_BR_TAKEN,
    output logic [31:0] NUM_INST,
    output logic [31:0] OUTPUT_PORT,
    output logic        HALT,
    output logic [31:0] CYCLE_CNT
);

    localparam logic [31:0] INST_ARM  = 32'h00c0_0093;
    localparam logic [31:0] INST_DONE = 32'h0000_8067;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_ARMED  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_num_inst;
    logic [31:0] r_output;
    logic [31:0] r_cycle_cnt;

    logic        w_active;
    logic        w_retire;
    logic        w_completes;
    logic        w_halt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (WB_VALID && (WB_INST == INST_ARM)) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (WB_VALID) begin
                    if (WB_INST == INST_DONE) begin
                        w_state_nxt = S_HALTED;
                    end else if (WB_INST != INST_ARM) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        w_active    = 1'b0;
        w_completes = 1'b0;
        w_halt      = 1'b0;
        case (r_state)
            S_RUN:    w_active = 1'b1;
            S_ARMED: begin
                w_active    = 1'b1;
                w_completes = WB_VALID && (WB_INST == INST_DONE);
            end
            S_HALTED: w_halt = 1'b1;
            default:  w_active = 1'b0;
        endcase
    end

    assign w_retire = w_active && WB_VALID;

    // The completing retirement is counted but leaves the result untouched.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_num_inst  <= P_NUM_INST_INIT;
            r_output    <= 32'h0;
            r_cycle_cnt <= 32'h0;
        end else if (w_active) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_retire) begin
                if (r_num_inst != 32'hFFFF_FFFF) begin
                    r_num_inst <= r_num_inst + 32'd1;
                end
                if (!w_completes) begin
                    if (WB_RF_WE) begin
                        r_output <= WB_WD;
                    end else if (WB_IS_STORE) begin
                        r_output <= WB_ADDR;
                    end else if (WB_IS_BRANCH) begin
                        r_output <= {31'b0, WB_BR_TAKEN};
                    end
                end
            end
        end
    end

    assign NUM_INST    = r_num_inst;
    assign OUTPUT_PORT = r_output;
    assign CYCLE_CNT   = r_cycle_cnt;
    assign HALT        = w_halt;

endmodule

// File: tb/tb_riscv_retire_tracker.sv
// Directed bench for riscv_retire_tracker; a second instance starts its
// instruction count near the top to exercise saturation.
module tb_riscv_retire_tracker;

    localparam logic [31:0] INST_ARM  = 32'h00c0_0093;
    localparam logic [31:0] INST_DONE = 32'h0000_8067;

    logic        CLK;
    logic        RST;
    logic        WB_VALID;
    logic [31:0] WB_INST;
    logic        WB_RF_WE;
    logic [31:0] WB_WD;
    logic        WB_IS_STORE;
    logic [31:0] WB_ADDR;
    logic        WB_IS_BRANCH;
    logic        WB_BR_TAKEN;
    logic [31:0] NUM_INST;
    logic [31:0] OUTPUT_PORT;
    logic        HALT;
    logic [31:0] CYCLE_CNT;
    logic [31:0] s_num_inst;
    logic [31:0] s_output;
    logic        s_halt;
    logic [31:0] s_cycle_cnt;

    int errors = 0;
    int checks = 0;

    riscv_retire_tracker dut (
        .CLK(CLK), .RST(RST), .WB_VALID(WB_VALID), .WB_INST(WB_INST),
        .WB_RF_WE(WB_RF_WE), .WB_WD(WB_WD), .WB_IS_STORE(WB_IS_STORE),
        .WB_ADDR(WB_ADDR), .WB_IS_BRANCH(WB_IS_BRANCH), .WB_BR_TAKEN(WB_BR_TAKEN),
        .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
        .CYCLE_CNT(CYCLE_CNT)
    );

    riscv_retire_tracker #(.P_NUM_INST_INIT(32'hFFFF_FFFE)) dut_sat (
        .CLK(CLK), .RST(RST), .WB_VALID(WB_VALID), .WB_INST(WB_INST),
        .WB_RF_WE(WB_RF_WE), .WB_WD(WB_WD), .WB_IS_STORE(WB_IS_STORE),
        .WB_ADDR(WB_ADDR), .WB_IS_BRANCH(WB_IS_BRANCH), .WB_BR_TAKEN(WB_BR_TAKEN),
        .NUM_INST(s_num_inst), .OUTPUT_PORT(s_output), .HALT(s_halt),
        .CYCLE_CNT(s_cycle_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        WB_VALID = 1'b0; WB_INST = 32'h0; WB_RF_WE = 1'b0; WB_WD = 32'h0;
        WB_IS_STORE = 1'b0; WB_ADDR = 32'h0; WB_IS_BRANCH = 1'b0; WB_BR_TAKEN = 1'b0;
    endtask

    task automatic retire(input logic [31:0] inst, input logic rf_we, input logic [31:0] wd,
                          input logic st, input logic [31:0] addr,
                          input logic br, input logic taken);
        WB_VALID = 1'b1; WB_INST = inst; WB_RF_WE = rf_we; WB_WD = wd;
        WB_IS_STORE = st; WB_ADDR = addr; WB_IS_BRANCH = br; WB_BR_TAKEN = taken;
        tick();
        clear_inputs();
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        WB_VALID = 1'b1; WB_INST = 32'h0050_0093; WB_RF_WE = 1'b1; WB_WD = 32'h99;
        tick();
        checks++; if (NUM_INST !== 32'h0) begin errors++; $display("FAIL reset_num got=%h exp=%h", NUM_INST, 32'h0); end
        checks++; if (OUTPUT_PORT !== 32'h0) begin errors++; $display("FAIL reset_out got=%h exp=%h", OUTPUT_PORT, 32'h0); end
        checks++; if (HALT !== 1'b0) begin errors++; $display("FAIL reset_halt got=%b exp=0", HALT); end
        checks++; if (CYCLE_CNT !== 32'h0) begin errors++; $display("FAIL reset_cyc got=%h exp=%h", CYCLE_CNT, 32'h0); end
        RST = 1'b0;
        clear_inputs();
        tick();
        checks++; if (CYCLE_CNT !== 32'd1) begin errors++; $display("FAIL first_cycle got=%0d exp=1", CYCLE_CNT); end
        idle(2);
        checks++; if (CYCLE_CNT !== 32'd3) begin errors++; $display("FAIL idle_cycles got=%0d exp=3", CYCLE_CNT); end
        checks++; if (NUM_INST !== 32'h0) begin errors++; $display("FAIL idle_num got=%h exp=%h", NUM_INST, 32'h0); end
    endtask

    task automatic test_addi();
        do_reset();
        retire(32'h0050_0093, 1'b1, 32'h5, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (NUM_INST !== 32'd1) begin errors++; $display("FAIL addi_num got=%h exp=%h", NUM_INST, 32'd1); end
        checks++; if (OUTPUT_PORT !== 32'h5) begin errors++; $display("FAIL addi_out got=%h exp=%h", OUTPUT_PORT, 32'h5); end
        checks++; if (HALT !== 1'b0) begin errors++; $display("FAIL addi_halt got=%b exp=0", HALT); end
        checks++; if (CYCLE_CNT !== 32'd1) begin errors++; $display("FAIL addi_cyc got=%0d exp=1", CYCLE_CNT); end
    endtask

    task automatic test_store_branch();
        do_reset();
        retire(32'h0400_a023, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0);
        checks++; if (OUTPUT_PORT !== 32'h40) begin errors++; $display("FAIL store_out got=%h exp=%h", OUTPUT_PORT, 32'h40); end
        retire(32'h0000_0463, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        checks++; if (OUTPUT_PORT !== 32'h1) begin errors++; $display("FAIL br_taken_out got=%h exp=%h", OUTPUT_PORT, 32'h1); end
        checks++; if (NUM_INST !== 32'd2) begin errors++; $display("FAIL store_br_num got=%h exp=%h", NUM_INST, 32'd2); end
        retire(32'h0000_0463, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (OUTPUT_PORT !== 32'h0) begin errors++; $display("FAIL br_nt_out got=%h exp=%h", OUTPUT_PORT, 32'h0); end
    endtask

    task automatic test_halt_seq();
        do_reset();
        retire(INST_ARM, 1'b1, 32'd12, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (HALT !== 1'b0) begin errors++; $display("FAIL armed_halt got=%b exp=0", HALT); end
        retire(INST_DONE, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (HALT !== 1'b1) begin errors++; $display("FAIL halt_set got=%b exp=1", HALT); end
        checks++; if (NUM_INST !== 32'd2) begin errors++; $display("FAIL halt_num got=%h exp=%h", NUM_INST, 32'd2); end
        checks++; if (OUTPUT_PORT !== 32'hC) begin errors++; $display("FAIL halt_out got=%h exp=%h", OUTPUT_PORT, 32'hC); end
        checks++; if (CYCLE_CNT !== 32'd2) begin errors++; $display("FAIL halt_cyc got=%0d exp=2", CYCLE_CNT); end
        retire(32'h0770_0093, 1'b1, 32'h77, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(2);
        checks++; if (NUM_INST !== 32'd2) begin errors++; $display("FAIL frozen_num got=%h exp=%h", NUM_INST, 32'd2); end
        checks++; if (OUTPUT_PORT !== 32'hC) begin errors++; $display("FAIL frozen_out got=%h exp=%h", OUTPUT_PORT, 32'hC); end
        checks++; if (CYCLE_CNT !== 32'd2) begin errors++; $display("FAIL frozen_cyc got=%0d exp=2", CYCLE_CNT); end
        checks++; if (HALT !== 1'b1) begin errors++; $display("FAIL halt_sticky got=%b exp=1", HALT); end
    endtask

    task automatic test_broken_seq();
        do_reset();
        retire(INST_ARM, 1'b1, 32'd12, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(3);
        retire(32'h0010_0113, 1'b1, 32'h1, 1'b0, 32'h0, 1'b0, 1'b0);
        retire(INST_DONE, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (HALT !== 1'b0) begin errors++; $display("FAIL broken_halt got=%b exp=0", HALT); end
        checks++; if (NUM_INST !== 32'd3) begin errors++; $display("FAIL broken_num got=%h exp=%h", NUM_INST, 32'd3); end
        checks++; if (OUTPUT_PORT !== 32'h8) begin errors++; $display("FAIL broken_out got=%h exp=%h", OUTPUT_PORT, 32'h8); end
        checks++; if (CYCLE_CNT !== 32'd6) begin errors++; $display("FAIL broken_cyc got=%0d exp=6", CYCLE_CNT); end
    endtask

    task automatic test_arm_repeat();
        do_reset();
        retire(INST_ARM, 1'b1, 32'd12, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(2);
        retire(INST_ARM, 1'b1, 32'd12, 1'b0, 32'h0, 1'b0, 1'b0);
        retire(INST_DONE, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (HALT !== 1'b1) begin errors++; $display("FAIL rearm_halt got=%b exp=1", HALT); end
        checks++; if (NUM_INST !== 32'd3) begin errors++; $display("FAIL rearm_num got=%h exp=%h", NUM_INST, 32'd3); end
    endtask

    task automatic test_priority();
        do_reset();
        retire(32'h0000_0013, 1'b1, 32'hAAAA, 1'b1, 32'hBBBB, 1'b1, 1'b1);
        checks++; if (OUTPUT_PORT !== 32'hAAAA) begin errors++; $display("FAIL prio_rf got=%h exp=%h", OUTPUT_PORT, 32'hAAAA); end
        retire(32'h0000_0013, 1'b0, 32'hAAAA, 1'b1, 32'hBBBB, 1'b1, 1'b1);
        checks++; if (OUTPUT_PORT !== 32'hBBBB) begin errors++; $display("FAIL prio_st got=%h exp=%h", OUTPUT_PORT, 32'hBBBB); end
        retire(32'h0000_0013, 1'b0, 32'h1234, 1'b0, 32'h5678, 1'b0, 1'b1);
        checks++; if (OUTPUT_PORT !== 32'hBBBB) begin errors++; $display("FAIL prio_hold got=%h exp=%h", OUTPUT_PORT, 32'hBBBB); end
        WB_VALID = 1'b0; WB_INST = INST_ARM; WB_RF_WE = 1'b1; WB_WD = 32'h1234;
        tick();
        retire(INST_DONE, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (OUTPUT_PORT !== 32'hBBBB) begin errors++; $display("FAIL invalid_out got=%h exp=%h", OUTPUT_PORT, 32'hBBBB); end
        checks++; if (NUM_INST !== 32'd4) begin errors++; $display("FAIL invalid_num got=%h exp=%h", NUM_INST, 32'd4); end
        checks++; if (HALT !== 1'b0) begin errors++; $display("FAIL invalid_halt got=%b exp=0", HALT); end
    endtask

    task automatic test_saturate();
        do_reset();
        checks++; if (s_num_inst !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_init got=%h exp=%h", s_num_inst, 32'hFFFF_FFFE); end
        retire(32'h0050_0093, 1'b1, 32'h5, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (s_num_inst !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_top got=%h exp=%h", s_num_inst, 32'hFFFF_FFFF); end
        retire(32'h0050_0093, 1'b1, 32'h5, 1'b0, 32'h0, 1'b0, 1'b0);
        retire(32'h0050_0093, 1'b1, 32'h5, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (s_num_inst !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold got=%h exp=%h", s_num_inst, 32'hFFFF_FFFF); end
        checks++; if (NUM_INST !== 32'd3) begin errors++; $display("FAIL sat_ref_num got=%h exp=%h", NUM_INST, 32'd3); end
    endtask

    task automatic test_reset_override();
        do_reset();
        retire(INST_ARM, 1'b1, 32'd12, 1'b0, 32'h0, 1'b0, 1'b0);
        RST = 1'b1;
        WB_VALID = 1'b1; WB_INST = INST_DONE; WB_RF_WE = 1'b1; WB_WD = 32'h8;
        tick();
        checks++; if ({NUM_INST, OUTPUT_PORT, CYCLE_CNT, HALT} !== 97'h0) begin errors++;
            $display("FAIL rst_armed got=%h/%h/%h/%b exp=0/0/0/0", NUM_INST, OUTPUT_PORT, CYCLE_CNT, HALT); end
        RST = 1'b0;
        retire(INST_DONE, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (HALT !== 1'b0) begin errors++; $display("FAIL rst_armed_state got=%b exp=0", HALT); end
        checks++; if (OUTPUT_PORT !== 32'h8) begin errors++; $display("FAIL rst_armed_out got=%h exp=%h", OUTPUT_PORT, 32'h8); end
        retire(INST_ARM, 1'b1, 32'd12, 1'b0, 32'h0, 1'b0, 1'b0);
        retire(INST_DONE, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (HALT !== 1'b1) begin errors++; $display("FAIL rst_pre_halt got=%b exp=1", HALT); end
        RST = 1'b1;
        WB_VALID = 1'b1; WB_INST = INST_ARM; WB_RF_WE = 1'b1; WB_WD = 32'd12;
        tick();
        checks++; if ({NUM_INST, OUTPUT_PORT, CYCLE_CNT, HALT} !== 97'h0) begin errors++;
            $display("FAIL rst_halted got=%h/%h/%h/%b exp=0/0/0/0", NUM_INST, OUTPUT_PORT, CYCLE_CNT, HALT); end
        RST = 1'b0;
        retire(INST_DONE, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (HALT !== 1'b0) begin errors++; $display("FAIL rst_halted_state got=%b exp=0", HALT); end
        checks++; if (NUM_INST !== 32'd1) begin errors++; $display("FAIL rst_halted_num got=%h exp=%h", NUM_INST, 32'd1); end
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        tick();
        test_reset();
        test_addi();
        test_store_branch();
        test_halt_seq();
        test_broken_seq();
        test_arm_repeat();
        test_priority();
        test_saturate();
        test_reset_override();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
